rtc_calendar: RTL and testbench
===============================

// Module: rtc_calendar
// PURPOSE
//  Calendar stage downstream of the RTC prescaler/counter, in the rtc_clk domain.
//  Consumes the 1 Hz second tick and keeps BCD-free binary sec/min/hour/wday/day/mon/year.
//  Provides software-style load and a masked alarm-match pulse for the interrupt logic.
//  Valid calendar range is 2000-2099; leap year = (year % 4 == 0).
// PARAMETERS
//  YEAR_WIDTH  7   width of year offset from 2000
//  YEAR_MAX    99  last year offset; year then wraps to 0
// PORTS
//  rtc_clk_i    in   1           RTC clock
//  rtc_rst_n_i  in   1           async active-low reset
//  en_i         in   1           calendar enable; 0 freezes time, ticks ignored
//  sec_tick_i   in   1           one-cycle pulse, advance one second
//  ld_i         in   1           one-cycle load strobe
//  ld_time_i    in   rtc_time_t  value to load
//  time_o       out  rtc_time_t  current time (registered)
//  day_carry_o  out  1           one-cycle pulse on 23:59:59 -> 00:00:00 rollover
//  ld_err_o     out  1           one-cycle pulse: load rejected (invalid field)
//  alrm_time_i  in   rtc_time_t  alarm compare value (sec/min/hour/day used)
//  alrm_mask_i  in   4           per-field ignore: [0]sec [1]min [2]hour [3]day
//  alrm_o       out  1           one-cycle alarm match pulse
// BEHAVIOUR
//  Reset: time_o = 2000-01-01 00:00:00, wday = 6 (Saturday).
//  Reset: day_carry_o, ld_err_o, alrm_o = 0; reset internal update flag.
//  Tick (en_i=1, sec_tick_i=1, ld_i=0): time_o advances on that same edge.
//  Tick result is visible one cycle after the tick is sampled.
//  Carry chain, each ripple within the same edge:
//   - sec 59->0 carries into min; min 59->0 carries into hour.
//   - hour 23->0 carries into day, wday and day_carry_o.
//   - wday wraps 6->0.
//   - day dim(mon,year)->1 carries into mon; dim(2) = 29 in leap years, else 28.
//   - mon 12->1 carries into year; year YEAR_MAX->0.
//  Load (ld_i=1): validated combinationally, all of:
//   - sec<60, min<60, hour<24, wday<7
//   - 1<=mon<=12, 1<=day<=dim(mon,year), year<=YEAR_MAX
//  Valid load: time_o = ld_time_i on the next edge.
//  Invalid load: time_o unchanged; ld_err_o pulses on the next edge.
//  Load accepted regardless of en_i.
//  Simultaneous ld_i and tick: load wins, tick discarded, no carry pulse.
//  en_i=0: ticks dropped (not queued); day_carry_o stays 0.
//  Alarm:
//   - Field match when equal or masked; compare registered against updated time_o.
//   - alrm_o pulses the cycle after a tick or valid load lands on a match.
//   - Evaluated only after an update (internal upd flag), so a static match pulses once.
//   - alrm_mask_i = 4'hF -> pulse after every update.
//   - Alarm inputs are quasi-static; a change while a match holds produces no pulse until the next update.
//  Reset mid-operation: all state returns to reset values asynchronously; pending pulses lost.
// CONFIGURATION
//  RTC_CAL_ALARM_EN defined:
//   - alarm comparator and alrm_o present as above.
//  RTC_CAL_ALARM_EN undefined:
//   - comparator and upd flag not built; alrm_o tied 0.
//   - alrm_time_i and alrm_mask_i ignored; ports keep the same list.
// STRUCTURE
//  Package rtc_cal_pkg holds the shared types and helpers:
//   - typedef rtc_time_t {year[YEAR_WIDTH-1:0], mon[3:0], day[4:0], wday[2:0],
//     hour[4:0], min[5:0], sec[5:0]}
//   - RTC_CAL_RST_TIME constant
//   - functions is_leap() and dim(mon,year)
//  Sub-module rtc_cal_field: generic wrapping counter with inputs inc/ld/ld_val/min/max.
//   - Outputs value and carry.
//   - Instanced per field; day's max is fed from dim().
// TESTING
//  - Reset, no ticks -> time_o = 2000-01-01 00:00:00 wday 6, all pulses 0.
//  - Load 2023-12-31 23:59:59 wday 0, one tick:
//    -> 2024-01-01 00:00:00 wday 1, day_carry_o one pulse.
//  - Load 2024-02-28 23:59:59, tick -> 02-29.
//    Load 2023-02-28 23:59:59, tick -> 03-01.
//  - Load 2023-02-29 -> ld_err_o pulse, time unchanged.
//    Load hour=24 -> same result.
//  - ld_i and sec_tick_i in the same cycle with 12:00:00 -> time = 12:00:00, no advance.
//    en_i=0 plus 5 ticks -> time unchanged.
//  - Alarm 00:00:30, mask 4'b1000, start 00:00:28, 3 ticks:
//    -> single alrm_o pulse one cycle after the 30 s update.
//    With RTC_CAL_ALARM_EN undefined -> alrm_o stays 0.

Source files
------------

// File: rtl/rtc_cal_pkg.sv
// Shared types and calendar helpers for the RTC calendar stage.
package rtc_cal_pkg;

    localparam int RTC_YEAR_W = 7;

    typedef struct packed {
        logic [RTC_YEAR_W-1:0] year;
        logic [3:0]            mon;
        logic [4:0]            day;
        logic [2:0]            wday;
        logic [4:0]            hour;
        logic [5:0]            min;
        logic [5:0]            sec;
    } rtc_time_t;

    // 2000-01-01 00:00:00, a Saturday
    localparam rtc_time_t RTC_CAL_RST_TIME = '{
        year: '0, mon: 4'd1, day: 5'd1, wday: 3'd6,
        hour: '0, min: '0, sec: '0
    };

    // The 2000-2099 range needs no century rule
    function automatic logic is_leap(input logic [RTC_YEAR_W-1:0] year);
        return (year[1:0] == 2'b00);
    endfunction

    function automatic logic [4:0] dim(input logic [3:0] mon,
                                       input logic [RTC_YEAR_W-1:0] year);
        case (mon)
            4'd2:                    dim = is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            default:                 dim = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_cal_field.sv
// Generic wrapping calendar field: load has priority over increment,
// and increment at max wraps to min while asserting carry.
module rtc_cal_field
    import rtc_cal_pkg::*;
#(
    parameter int           W       = 6,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_ld,
    input  logic [W-1:0] i_ld_val,
    input  logic [W-1:0] i_min,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_value,
    output logic         o_carry
);

    logic [W-1:0] r_val;
    logic         w_at_max;

    // >= rather than == so an out-of-range value still wraps cleanly
    assign w_at_max = (r_val >= i_max);
    assign o_carry  = i_inc & ~i_ld & w_at_max;
    assign o_value  = r_val;

    // Field register: load, else wrap/increment on inc
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_val <= RST_VAL;
        else if (i_ld)
            r_val <= i_ld_val;
        else if (i_inc)
            r_val <= w_at_max ? i_min : r_val + 1'b1;
    end

endmodule

// File: rtl/rtc_calendar.sv
// RTC calendar stage: binary sec/min/hour/wday/day/mon/year driven by the
// 1 Hz tick, with validated software load and an optional masked alarm.
// Optional feature macro: RTC_CAL_ALARM_EN (alarm comparator and alrm_o).
module rtc_calendar
    import rtc_cal_pkg::*;
#(
    parameter int YEAR_WIDTH = RTC_YEAR_W,
    parameter int YEAR_MAX   = 99
) (
    input  logic       rtc_clk_i,
    input  logic       rtc_rst_n_i,
    input  logic       en_i,
    input  logic       sec_tick_i,
    input  logic       ld_i,
    input  rtc_time_t  ld_time_i,
    output rtc_time_t  time_o,
    output logic       day_carry_o,
    output logic       ld_err_o,
    input  rtc_time_t  alrm_time_i,
    input  logic [3:0] alrm_mask_i,
    output logic       alrm_o
);

    localparam logic [RTC_YEAR_W-1:0] LP_YEAR_MAX = YEAR_WIDTH'(YEAR_MAX);

    logic                  w_tick, w_ld_ok, w_ld;
    logic                  w_sec_c, w_min_c, w_hour_c, w_day_c, w_mon_c;
    logic                  w_wday_unused_c, w_year_unused_c;
    logic [5:0]            w_sec, w_min;
    logic [4:0]            w_hour, w_day, w_dim;
    logic [2:0]            w_wday;
    logic [3:0]            w_mon;
    logic [RTC_YEAR_W-1:0] w_year;
    logic                  r_day_carry, r_ld_err;

    // Load beats a simultaneous tick; a disabled calendar drops ticks
    assign w_tick = en_i & sec_tick_i & ~ld_i;

    assign w_ld_ok = (ld_time_i.sec  < 6'd60) && (ld_time_i.min < 6'd60) &&
                     (ld_time_i.hour < 5'd24) && (ld_time_i.wday < 3'd7) &&
                     (ld_time_i.mon >= 4'd1)  && (ld_time_i.mon <= 4'd12) &&
                     (ld_time_i.day >= 5'd1)  &&
                     (ld_time_i.day <= dim(ld_time_i.mon, ld_time_i.year)) &&
                     (ld_time_i.year <= LP_YEAR_MAX);
    assign w_ld    = ld_i & w_ld_ok;
    assign w_dim   = dim(w_mon, w_year);

    rtc_cal_field #(.W(6), .RST_VAL(RTC_CAL_RST_TIME.sec)) u_sec (
        .i_clk(rtc_clk_i), .i_rst_n(rtc_rst_n_i), .i_inc(w_tick), .i_ld(w_ld),
        .i_ld_val(ld_time_i.sec), .i_min(6'd0), .i_max(6'd59),
        .o_value(w_sec), .o_carry(w_sec_c));

    rtc_cal_field #(.W(6), .RST_VAL(RTC_CAL_RST_TIME.min)) u_min (
        .i_clk(rtc_clk_i), .i_rst_n(rtc_rst_n_i), .i_inc(w_sec_c), .i_ld(w_ld),
        .i_ld_val(ld_time_i.min), .i_min(6'd0), .i_max(6'd59),
        .o_value(w_min), .o_carry(w_min_c));

    rtc_cal_field #(.W(5), .RST_VAL(RTC_CAL_RST_TIME.hour)) u_hour (
        .i_clk(rtc_clk_i), .i_rst_n(rtc_rst_n_i), .i_inc(w_min_c), .i_ld(w_ld),
        .i_ld_val(ld_time_i.hour), .i_min(5'd0), .i_max(5'd23),
        .o_value(w_hour), .o_carry(w_hour_c));

    rtc_cal_field #(.W(3), .RST_VAL(RTC_CAL_RST_TIME.wday)) u_wday (
        .i_clk(rtc_clk_i), .i_rst_n(rtc_rst_n_i), .i_inc(w_hour_c), .i_ld(w_ld),
        .i_ld_val(ld_time_i.wday), .i_min(3'd0), .i_max(3'd6),
        .o_value(w_wday), .o_carry(w_wday_unused_c));

    rtc_cal_field #(.W(5), .RST_VAL(RTC_CAL_RST_TIME.day)) u_day (
        .i_clk(rtc_clk_i), .i_rst_n(rtc_rst_n_i), .i_inc(w_hour_c), .i_ld(w_ld),
        .i_ld_val(ld_time_i.day), .i_min(5'd1), .i_max(w_dim),
        .o_value(w_day), .o_carry(w_day_c));

    rtc_cal_field #(.W(4), .RST_VAL(RTC_CAL_RST_TIME.mon)) u_mon (
        .i_clk(rtc_clk_i), .i_rst_n(rtc_rst_n_i), .i_inc(w_day_c), .i_ld(w_ld),
        .i_ld_val(ld_time_i.mon), .i_min(4'd1), .i_max(4'd12),
        .o_value(w_mon), .o_carry(w_mon_c));

    rtc_cal_field #(.W(RTC_YEAR_W), .RST_VAL(RTC_CAL_RST_TIME.year)) u_year (
        .i_clk(rtc_clk_i), .i_rst_n(rtc_rst_n_i), .i_inc(w_mon_c), .i_ld(w_ld),
        .i_ld_val(ld_time_i.year), .i_min('0), .i_max(LP_YEAR_MAX),
        .o_value(w_year), .o_carry(w_year_unused_c));

    assign time_o = {w_year, w_mon, w_day, w_wday, w_hour, w_min, w_sec};

    // Single-cycle status pulses: midnight rollover and rejected load
    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            r_day_carry <= 1'b0;
            r_ld_err    <= 1'b0;
        end else begin
            r_day_carry <= w_hour_c;
            r_ld_err    <= ld_i & ~w_ld_ok;
        end
    end

    assign day_carry_o = r_day_carry;
    assign ld_err_o    = r_ld_err;

`ifdef RTC_CAL_ALARM_EN
    logic r_upd, r_alrm, w_match;

    assign w_match = (alrm_mask_i[0] | (time_o.sec  == alrm_time_i.sec))  &
                     (alrm_mask_i[1] | (time_o.min  == alrm_time_i.min))  &
                     (alrm_mask_i[2] | (time_o.hour == alrm_time_i.hour)) &
                     (alrm_mask_i[3] | (time_o.day  == alrm_time_i.day));

    // Compare only once after each time update so a held match pulses once
    always_ff @(posedge rtc_clk_i or negedge rtc_rst_n_i) begin
        if (!rtc_rst_n_i) begin
            r_upd  <= 1'b0;
            r_alrm <= 1'b0;
        end else begin
            r_upd  <= w_tick | w_ld;
            r_alrm <= r_upd & w_match;
        end
    end

    assign alrm_o = r_alrm;
`else
    logic w_alrm_unused;
    assign w_alrm_unused = ^{alrm_time_i, alrm_mask_i};
    assign alrm_o        = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed, table-driven bench for rtc_calendar.
module tb_rtc_calendar;
    import rtc_cal_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i = 1'b1;
    logic       sec_tick_i = 1'b0;
    logic       ld_i = 1'b0;
    rtc_time_t  ld_time_i = '0;
    rtc_time_t  time_o;
    logic       day_carry_o, ld_err_o, alrm_o;
    rtc_time_t  alrm_time_i = '0;
    logic [3:0] alrm_mask_i = 4'h0;

    int n_vec = 0;
    int n_bad = 0;

    rtc_calendar dut (
        .rtc_clk_i(clk), .rtc_rst_n_i(rst_n), .en_i(en_i), .sec_tick_i(sec_tick_i),
        .ld_i(ld_i), .ld_time_i(ld_time_i), .time_o(time_o),
        .day_carry_o(day_carry_o), .ld_err_o(ld_err_o),
        .alrm_time_i(alrm_time_i), .alrm_mask_i(alrm_mask_i), .alrm_o(alrm_o));

    always #5 clk = ~clk;

    typedef struct {
        rtc_time_t base;
        rtc_time_t ldv;
        int        ticks;
        logic      en;
        rtc_time_t exp_t;
        int        exp_carry;
        logic      exp_err;
    } vec_t;

    vec_t vecs[12];

    function automatic rtc_time_t mk(int y, int mo, int d, int wd, int h, int mi, int s);
        rtc_time_t r;
        r.year = 7'(y); r.mon = 4'(mo); r.day = 5'(d); r.wday = 3'(wd);
        r.hour = 5'(h); r.min = 6'(mi); r.sec = 6'(s);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input rtc_time_t t, output logic err);
        @(negedge clk);
        ld_i = 1'b1; ld_time_i = t;
        @(posedge clk); #1;
        err = ld_err_o;
        ld_i = 1'b0;
    endtask

    task automatic do_tick(inout int carries);
        @(negedge clk);
        sec_tick_i = 1'b1;
        @(posedge clk); #1;
        carries += int'(day_carry_o);
        sec_tick_i = 1'b0;
    endtask

    initial begin
        logic      err;
        int        car;
        logic [7:0] pat, exp_pat;
        rtc_time_t base;

        vecs[0]  = '{mk(23,12,31,0,23,59,59), mk(23,12,31,0,23,59,59), 1, 1'b1, mk(24,1,1,1,0,0,0), 1, 1'b0};
        vecs[1]  = '{mk(24,2,28,3,23,59,59),  mk(24,2,28,3,23,59,59),  1, 1'b1, mk(24,2,29,4,0,0,0), 1, 1'b0};
        vecs[2]  = '{mk(23,2,28,2,23,59,59),  mk(23,2,28,2,23,59,59),  1, 1'b1, mk(23,3,1,3,0,0,0),  1, 1'b0};
        vecs[3]  = '{mk(23,5,5,5,10,0,0),     mk(23,2,29,3,0,0,0),     0, 1'b1, mk(23,5,5,5,10,0,0), 0, 1'b1};
        vecs[4]  = '{mk(23,5,5,5,10,0,0),     mk(23,5,6,6,24,0,0),     0, 1'b1, mk(23,5,5,5,10,0,0), 0, 1'b1};
        vecs[5]  = '{mk(23,5,5,5,10,0,0),     mk(23,5,5,5,10,0,0),     5, 1'b0, mk(23,5,5,5,10,0,0), 0, 1'b0};
        vecs[6]  = '{mk(99,12,31,4,23,59,59), mk(99,12,31,4,23,59,59), 1, 1'b1, mk(0,1,1,5,0,0,0),   1, 1'b0};
        vecs[7]  = '{mk(24,3,2,6,23,59,59),   mk(24,3,2,6,23,59,59),   1, 1'b1, mk(24,3,3,0,0,0,0),  1, 1'b0};
        vecs[8]  = '{mk(24,6,30,0,12,58,59),  mk(24,6,30,0,12,58,59), 61, 1'b1, mk(24,6,30,0,13,0,0), 0, 1'b0};
        vecs[9]  = '{mk(24,4,30,2,23,59,59),  mk(24,4,30,2,23,59,59),  1, 1'b1, mk(24,5,1,3,0,0,0),  1, 1'b0};
        vecs[10] = '{mk(23,5,5,5,10,0,0),     mk(23,13,1,0,0,0,0),     0, 1'b1, mk(23,5,5,5,10,0,0), 0, 1'b1};
        vecs[11] = '{mk(23,5,5,5,10,0,0),     mk(23,6,0,0,0,0,0),      1, 1'b1, mk(23,5,5,5,10,0,1), 0, 1'b1};

        // Alarm parked on day 0 (never valid) so table loads do not trigger it
        alrm_time_i = mk(0,1,0,0,23,59,59);
        alrm_mask_i = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_time", 64'(time_o), 64'(mk(0,1,1,6,0,0,0)));
        chk("reset_day_carry", 64'(day_carry_o), 64'd0);
        chk("reset_ld_err", 64'(ld_err_o), 64'd0);
        chk("reset_alrm", 64'(alrm_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_time", 64'(time_o), 64'(mk(0,1,1,6,0,0,0)));

        for (int i = 0; i < 12; i++) begin
            en_i = 1'b1;
            do_load(vecs[i].base, err);
            do_load(vecs[i].ldv, err);
            chk($sformatf("v%0d_ld_err", i), 64'(err), 64'(vecs[i].exp_err));
            en_i = vecs[i].en;
            car = 0;
            for (int k = 0; k < vecs[i].ticks; k++) do_tick(car);
            en_i = 1'b1;
            chk($sformatf("v%0d_time", i), 64'(time_o), 64'(vecs[i].exp_t));
            chk($sformatf("v%0d_carries", i), 64'(car), 64'(vecs[i].exp_carry));
        end

        // Load and tick together: load wins, no advance, no carry
        do_load(mk(24,1,1,1,23,59,59), err);
        @(negedge clk);
        ld_i = 1'b1; ld_time_i = mk(24,1,2,2,12,0,0); sec_tick_i = 1'b1;
        @(posedge clk); #1;
        chk("ldtick_carry", 64'(day_carry_o), 64'd0);
        ld_i = 1'b0; sec_tick_i = 1'b0;
        @(posedge clk); #1;
        chk("ldtick_time", 64'(time_o), 64'(mk(24,1,2,2,12,0,0)));

        // Alarm at 00:00:30 with day ignored, three ticks from 00:00:28
        alrm_time_i = mk(0,1,1,0,0,0,30);
        alrm_mask_i = 4'b1000;
        do_load(mk(24,1,1,1,0,0,28), err);
        pat = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            sec_tick_i = (c < 3);
            @(posedge clk); #1;
            pat[c] = alrm_o;
        end
        sec_tick_i = 1'b0;
`ifdef RTC_CAL_ALARM_EN
        exp_pat = 8'b0000_0100;
`else
        exp_pat = 8'h00;
`endif
        chk("alarm_sec30_pattern", 64'(pat), 64'(exp_pat));

        // Mask change while static: no pulse; then a load with full mask pulses once
        alrm_mask_i = 4'hF;
        pat = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            pat[c] = alrm_o;
        end
        chk("alarm_mask_change", 64'(pat), 64'd0);
        do_load(mk(24,1,1,1,5,5,5), err);
        pat = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            pat[c] = alrm_o;
        end
`ifdef RTC_CAL_ALARM_EN
        exp_pat = 8'b0000_0001;
`else
        exp_pat = 8'h00;
`endif
        chk("alarm_maskF_once", 64'(pat), 64'(exp_pat));
        alrm_mask_i = 4'h0;

        // Asynchronous reset right after a midnight rollover
        base = mk(24,7,4,4,23,59,59);
        do_load(base, err);
        car = 0;
        do_tick(car);
        chk("pre_reset_carry", 64'(car), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_time", 64'(time_o), 64'(mk(0,1,1,6,0,0,0)));
        chk("async_reset_carry", 64'(day_carry_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
